// File: rtl/conv_layer_sched.sv
// rtl/conv_layer_sched.sv - multi-layer ConvAcc descriptor sequencer
//
// Walks a descriptor table of N layers. For each layer it fetches
// {mode, w8}, pulses acc_start_o and waits for acc_finish_i, then swaps the
// ping-pong role of the two activation SRAMs (buf_sel_o).
//
// Optional feature macro: SCHED_WDOG_EN (RUN-state watchdog driving err_o).
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   run_i, num_layers_i  start a sequence of num_layers_i layers (IDLE only)
//   abort_i              abandon the sequence from any non-IDLE state
//   desc_addr_o          descriptor table read address
//   desc_rdata_i         {mode[3:0], w8[31:0]}, valid 1 cycle after address
//   acc_start_o          1-cycle start pulse to ConvAcc
//   acc_mode_o, acc_w8_o layer command, held stable while ConvAcc runs
//   acc_finish_i         ConvAcc finish
//   buf_sel_o            0: SRAM A input / B output, 1: swapped
//   layer_idx_o          current layer index
//   busy_o               high outside IDLE
//   done_o               1-cycle pulse after the last layer (or N=0)
//   err_o                sticky watchdog error
module conv_layer_sched #(
  parameter int MAX_LAYERS = 16,
  parameter int LW         = 5,
  parameter int WDOG_CYC   = 2**20,
  localparam int AW        = $clog2(MAX_LAYERS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          run_i,
  input  logic          abort_i,
  input  logic [LW-1:0] num_layers_i,
  output logic [AW-1:0] desc_addr_o,
  input  logic [35:0]   desc_rdata_i,
  output logic          acc_start_o,
  output logic [3:0]    acc_mode_o,
  output logic [31:0]   acc_w8_o,
  input  logic          acc_finish_i,
  output logic          buf_sel_o,
  output logic [AW-1:0] layer_idx_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_RD, S_LAUNCH, S_RUN, S_NEXT, S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] idx;
  logic [LW-1:0] n_lat;
  logic          last_layer;
  logic          wdog_expire;
  logic          aborting;

  assign aborting    = (state != S_IDLE) && abort_i;
  assign last_layer  = (LW'(idx) == (n_lat - LW'(1)));
  assign desc_addr_o = idx;
  assign layer_idx_o = idx;
  assign acc_start_o = (state == S_LAUNCH);
  assign busy_o      = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (run_i) state_nx = (num_layers_i == '0) ? S_DONE : S_FETCH;
      S_FETCH:   state_nx = S_WAIT_RD;
      S_WAIT_RD: state_nx = S_LAUNCH;
      S_LAUNCH:  state_nx = S_RUN;
      // finish on the expiry cycle still counts as success
      S_RUN: begin
        if (acc_finish_i)     state_nx = S_NEXT;
        else if (wdog_expire) state_nx = S_IDLE;
      end
      S_NEXT:    state_nx = last_layer ? S_DONE : S_FETCH;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
    if (aborting) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      idx        <= '0;
      n_lat      <= '0;
      buf_sel_o  <= 1'b0;
      acc_mode_o <= '0;
      acc_w8_o   <= '0;
      done_o     <= 1'b0;
    end else begin
      state  <= state_nx;
      // done_o is registered off DONE, so it lands 2 clk after run_i for N=0
      done_o <= (state == S_DONE) && !abort_i;
      case (state)
        S_IDLE: begin
          if (run_i) begin
            n_lat     <= (num_layers_i > LW'(MAX_LAYERS)) ? LW'(MAX_LAYERS) : num_layers_i;
            idx       <= '0;
            buf_sel_o <= 1'b0;
          end
        end
        S_WAIT_RD: begin
          acc_mode_o <= desc_rdata_i[35:32];
          acc_w8_o   <= desc_rdata_i[31:0];
        end
        S_NEXT: begin
          buf_sel_o <= ~buf_sel_o;
          if (!last_layer) idx <= idx + AW'(1);
        end
        default: ;
      endcase
      if (aborting) begin
        idx       <= '0;
        buf_sel_o <= 1'b0;
      end
    end
  end

`ifdef SCHED_WDOG_EN
  localparam int CW = $clog2(WDOG_CYC + 1);
  logic [CW-1:0] wdog_cnt;

  // counter holds the number of completed RUN cycles; expiry on the WDOG_CYC-th
  assign wdog_expire = (state == S_RUN) && (wdog_cnt == CW'(WDOG_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wdog_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      if (state == S_LAUNCH)   wdog_cnt <= '0;
      else if (state == S_RUN) wdog_cnt <= wdog_cnt + CW'(1);
      if ((state == S_IDLE) && run_i)
        err_o <= 1'b0;
      else if (wdog_expire && !acc_finish_i && !abort_i)
        err_o <= 1'b1;
    end
  end
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_CYC;
  assign wdog_expire     = 1'b0;
  assign err_o           = 1'b0;
`endif

endmodule

// File: tb/tb_conv_layer_sched.sv
// tb/tb_conv_layer_sched.sv - randomized self-checking bench for conv_layer_sched
//
// Drives the scheduler against a synchronous descriptor memory and a reactive
// ConvAcc that finishes a chosen number of cycles after each start. Expected
// start/done cycles, commands and buffer selects come from an event-time model.
// Build with SCHED_WDOG_EN to also exercise the watchdog (WDOG_CYC = 64).
module tb_conv_layer_sched;
  localparam int MAX_LAYERS = 16;
  localparam int LW         = 5;
  localparam int AW         = 4;
`ifdef SCHED_WDOG_EN
  localparam int WDOG_CYC   = 64;
`else
  localparam int WDOG_CYC   = 1 << 20;
`endif

  logic          clk, rstn, run, abort, finish;
  logic [LW-1:0] num_layers;
  logic [AW-1:0] desc_addr, layer_idx;
  logic [35:0]   desc_rdata;
  logic          acc_start, buf_sel, busy, done, err;
  logic [3:0]    acc_mode;
  logic [31:0]   acc_w8;
  logic [35:0]   desc_mem [MAX_LAYERS];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  conv_layer_sched #(.MAX_LAYERS(MAX_LAYERS), .LW(LW), .WDOG_CYC(WDOG_CYC)) dut (
    .clk(clk), .rstn(rstn), .run_i(run), .abort_i(abort), .num_layers_i(num_layers),
    .desc_addr_o(desc_addr), .desc_rdata_i(desc_rdata), .acc_start_o(acc_start),
    .acc_mode_o(acc_mode), .acc_w8_o(acc_w8), .acc_finish_i(finish),
    .buf_sel_o(buf_sel), .layer_idx_o(layer_idx), .busy_o(busy), .done_o(done),
    .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) desc_rdata <= desc_mem[desc_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // advance one clock; inputs are pulses by default
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    run    = 1'b0;
    finish = 1'b0;
    abort  = 1'b0;
  endtask

  // one sequence: dly=0 picks random finish delays; abort_layer<0 means no abort
  task automatic run_seq(input int n_req, input int dly, input int abort_layer,
                         input bit extra_run, input bit fill);
    int  n_eff, k, c0, exp_start, exp_done, fin, idle_from, end_c, extra_c;
    bit  aborted, finished;
    n_eff = (n_req > MAX_LAYERS) ? MAX_LAYERS : n_req;
    if (fill)
      for (int i = 0; i < MAX_LAYERS; i++) desc_mem[i] = {4'($urandom), 32'($urandom)};
    tick();
    c0 = cyc;
    check("idle_busy", busy, 1'b0);
    run        = 1'b1;
    num_layers = LW'(n_req);
    k = 0; fin = -1; extra_c = -1; aborted = 0; finished = 0;
    if (n_eff == 0) begin
      exp_start = -1; exp_done = c0 + 2; idle_from = c0 + 2; end_c = c0 + 5;
    end else begin
      exp_start = c0 + 3; exp_done = -1; idle_from = 1 << 30; end_c = -1;
    end
    repeat (4000) begin
      tick();
      if (end_c >= 0 && cyc > end_c) begin
        finished = 1;
        break;
      end
      check("start", acc_start, cyc == exp_start);
      check("done", done, cyc == exp_done);
      check("busy", busy, cyc < idle_from);
      check("err", err, 1'b0);
      if (cyc == exp_start) begin
        check("mode", acc_mode, desc_mem[k][35:32]);
        check("w8", acc_w8, desc_mem[k][31:0]);
        check("layer_idx", layer_idx, k);
        check("desc_addr", desc_addr, k);
        check("buf_sel_run", buf_sel, k % 2);
        fin = cyc + ((dly > 0) ? dly : int'($urandom_range(1, 8)));
        if (extra_run && k == 0) extra_c = cyc + 1;
      end
      if (cyc == extra_c) begin
        run        = 1'b1;
        num_layers = LW'($urandom_range(1, 20));
      end
      if (aborted && cyc >= idle_from) begin
        check("abort_idx", layer_idx, 0);
        check("abort_buf_sel", buf_sel, 1'b0);
      end
      if (!aborted && n_eff > 0 && cyc == exp_done) begin
        check("end_buf_sel", buf_sel, n_eff % 2);
        check("end_idx", layer_idx, n_eff - 1);
      end
      if (cyc == fin) begin
        finish = 1'b1;
        check("hold_mode", acc_mode, desc_mem[k][35:32]);
        check("hold_w8", acc_w8, desc_mem[k][31:0]);
        if (k == abort_layer) begin
          abort = 1'b1; aborted = 1; exp_start = -1;
          idle_from = cyc + 1; end_c = cyc + 4;
        end else if (k == n_eff - 1) begin
          exp_done = cyc + 3; idle_from = cyc + 3; end_c = cyc + 5;
        end else begin
          k++;
          exp_start = cyc + 4;
        end
      end
    end
    check("seq_complete", finished, 1'b1);
  endtask

  initial begin
    rstn = 1'b0; run = 1'b0; abort = 1'b0; finish = 1'b0; num_layers = '0;
    for (int i = 0; i < MAX_LAYERS; i++) desc_mem[i] = '0;
    desc_mem[0] = {4'd1, 32'hA};
    desc_mem[1] = {4'd2, 32'hB};
    desc_mem[2] = {4'd3, 32'hC};
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_start", acc_start, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_idx", layer_idx, 0);
    check("rst_addr", desc_addr, 0);
    check("rst_buf_sel", buf_sel, 1'b0);
    check("rst_mode", acc_mode, 0);
    check("rst_w8", acc_w8, 0);
    rstn = 1'b1;
    tick();

    run_seq(3, 10, -1, 0, 0);
    run_seq(0, 0, -1, 0, 0);
    run_seq(4, 0, 1, 0, 1);
    run_seq(5, 0, -1, 1, 1);
    run_seq(20, 0, -1, 0, 1);
    repeat (6) run_seq($urandom_range(0, 20), 0, -1, $urandom_range(0, 1), 1);

    // reset for a single cycle while ConvAcc is running
    tick();
    run = 1'b1; num_layers = LW'(2);
    repeat (4) tick();
    check("pre_rst_busy", busy, 1'b1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_idx", layer_idx, 0);
    check("mid_rst_buf_sel", buf_sel, 1'b0);
    check("mid_rst_mode", acc_mode, 0);
    check("mid_rst_w8", acc_w8, 0);
    check("mid_rst_err", err, 1'b0);
    repeat (4) begin
      tick();
      check("post_rst_start", acc_start, 1'b0);
      check("post_rst_done", done, 1'b0);
    end
    run_seq(1, 0, -1, 0, 1);

`ifdef SCHED_WDOG_EN
    begin
      int c0;
      tick();
      c0 = cyc;
      run = 1'b1; num_layers = LW'(1);
      while (cyc < c0 + 72) begin
        tick();
        check("wdog_done", done, 1'b0);
        if (cyc < c0 + 68) check("wdog_err_pre", err, 1'b0);
        if (cyc >= c0 + 68) begin
          check("wdog_err", err, 1'b1);
          check("wdog_busy", busy, 1'b0);
        end
      end
    end
    run_seq(1, WDOG_CYC, -1, 0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
